// File: rtl/ISO14443A_pkg.sv
// Shared ISO14443A types for the PCD->PICC receive path: Miller sequence symbols,
// bit-rate selection and the state encoding of the multirate sequence decoder.
package ISO14443A_pkg;

  typedef enum logic [1:0] {
    PCDBitSequence_ERROR = 2'd0,
    PCDBitSequence_X     = 2'd1,
    PCDBitSequence_Y     = 2'd2,
    PCDBitSequence_Z     = 2'd3
  } PCDBitSequence;

  typedef enum logic [1:0] {
    PCDBitRate_106 = 2'd0,
    PCDBitRate_212 = 2'd1,
    PCDBitRate_424 = 2'd2,
    PCDBitRate_848 = 2'd3
  } PCDBitRate;

  // Shortest bit period (clk cycles) the decoder is designed to support.
  localparam int SEQ_DEC_MIN_BIT_LEN = 16;

  typedef enum logic [1:0] {
    SEQ_DEC_IDLE    = 2'd0,
    SEQ_DEC_ACTIVE  = 2'd1,
    SEQ_DEC_RECOVER = 2'd2
  } seq_dec_state_t;

endpackage

// File: rtl/sequence_decode_multirate_bit_timer.sv
// Loadable modulo-L bit timer (L = BIT_LEN_106 >> rate) with EARLY/MID/LATE window
// flags, the Y-emission point and the wrap strobe used by the sequence decoder.
module sequence_decode_bit_timer
  import ISO14443A_pkg::*;
#(
  parameter int BIT_LEN_106 = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] rate,
  input  logic       run,
  input  logic       load_zero,
  input  logic       load_half,
  output logic       early,
  output logic       mid,
  output logic       late,
  output logic       y_point,
  output logic       wrap
);

  localparam int TW = $clog2(BIT_LEN_106);

  int unsigned   len;
  logic [TW-1:0] t;
  logic [TW-1:0] len_m1;
  logic [TW-1:0] quarter;
  logic [TW-1:0] half;
  logic [TW-1:0] three_q;

  always_comb begin
    len     = BIT_LEN_106 >> rate;
    len_m1  = TW'(len - 1);
    quarter = TW'(len >> 2);
    half    = TW'(len >> 1);
    three_q = TW'(len - (len >> 2));
  end

  assign early   = (t < quarter);
  assign late    = (t >= three_q);
  assign mid     = !early && !late;
  assign y_point = (t == three_q - 1'b1);
  assign wrap    = (t == len_m1);

  // Loads take priority over counting so a pause on the wrap cycle resynchronises the bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      t <= '0;
    end else if (load_zero) begin
      t <= '0;
    end else if (load_half) begin
      t <= half;
    end else if (run) begin
      t <= wrap ? '0 : t + 1'b1;
    end
  end

endmodule

// File: rtl/sequence_decode_multirate.sv
// Modified-Miller X/Y/Z/ERROR sequence decoder at a runtime-selectable bit rate.
// Optional SEQ_DECODE_STATS_EN adds a saturating ERROR counter on err_count.
module sequence_decode_multirate
  import ISO14443A_pkg::*;
#(
  parameter int BIT_LEN_106 = 128
`ifdef SEQ_DECODE_STATS_EN
  , parameter int ERR_CNT_W = 8
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pause_n_synchronised,
  input  logic [1:0]    rate_sel,
  output PCDBitSequence seq,
  output logic          seq_valid,
  output logic          idle
`ifdef SEQ_DECODE_STATS_EN
  , output logic [ERR_CNT_W-1:0] err_count
`endif
);

  seq_dec_state_t state, state_n;
  PCDBitRate      rate_q, rate_n;
  PCDBitSequence  last, last_n, seq_n;
  logic pause_n_q, pause_evt;
  logic bit_done, bit_done_n;
  logic y_seen, y_seen_n;
  logic seq_valid_n, idle_n, raise_err;
  logic run, load_zero, load_half;
  logic early, mid, late, y_point, wrap, late_eff;

  sequence_decode_bit_timer #(.BIT_LEN_106(BIT_LEN_106)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .rate      (rate_q),
    .run       (run),
    .load_zero (load_zero),
    .load_half (load_half),
    .early     (early),
    .mid       (mid),
    .late      (late),
    .y_point   (y_point),
    .wrap      (wrap)
  );

  assign pause_evt = pause_n_q && !pause_n_synchronised;
  // A pause landing on the Y-emission cycle belongs to the next bit.
  assign late_eff  = late || y_point;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no latch can be inferred.
    state_n     = state;
    rate_n      = rate_q;
    last_n      = last;
    bit_done_n  = bit_done && !wrap;
    y_seen_n    = y_seen;
    seq_n       = seq;
    seq_valid_n = 1'b0;
    idle_n      = idle;
    raise_err   = 1'b0;
    load_zero   = 1'b0;
    load_half   = 1'b0;
    run         = (state != SEQ_DEC_IDLE);

    unique case (state)
      SEQ_DEC_IDLE: begin
        if (pause_evt) begin
          rate_n      = PCDBitRate'(rate_sel);
          seq_n       = PCDBitSequence_Z;
          seq_valid_n = 1'b1;
          last_n      = PCDBitSequence_Z;
          bit_done_n  = 1'b1;
          load_zero   = 1'b1;
          idle_n      = 1'b0;
          state_n     = SEQ_DEC_ACTIVE;
        end
      end

      SEQ_DEC_ACTIVE: begin
        if (pause_evt) begin
          bit_done_n = 1'b1;
          if (late_eff || (early && !bit_done)) begin
            load_zero = 1'b1;
            if (last == PCDBitSequence_X) begin
              raise_err = 1'b1;
            end else begin
              seq_n       = PCDBitSequence_Z;
              seq_valid_n = 1'b1;
              last_n      = PCDBitSequence_Z;
            end
          end else if (mid && !bit_done) begin
            load_half   = 1'b1;
            seq_n       = PCDBitSequence_X;
            seq_valid_n = 1'b1;
            last_n      = PCDBitSequence_X;
          end else begin
            // Second pause inside an already decoded bit: spurious, keep the bit timing.
            raise_err = 1'b1;
          end
          if (raise_err) begin
            seq_n       = PCDBitSequence_ERROR;
            seq_valid_n = 1'b1;
            y_seen_n    = 1'b0;
            state_n     = SEQ_DEC_RECOVER;
          end
        end else if (y_point && !bit_done) begin
          bit_done_n  = 1'b1;
          seq_n       = PCDBitSequence_Y;
          seq_valid_n = 1'b1;
          last_n      = PCDBitSequence_Y;
          if (last == PCDBitSequence_Y) begin
            idle_n  = 1'b1;
            state_n = SEQ_DEC_IDLE;
          end
        end
      end

      SEQ_DEC_RECOVER: begin
        if (pause_evt) begin
          bit_done_n = 1'b1;
          y_seen_n   = 1'b0;
          load_zero  = late_eff;
        end else if (y_point && !bit_done) begin
          bit_done_n  = 1'b1;
          seq_n       = PCDBitSequence_Y;
          seq_valid_n = 1'b1;
          last_n      = PCDBitSequence_Y;
          if (y_seen) begin
            idle_n  = 1'b1;
            state_n = SEQ_DEC_IDLE;
          end else begin
            y_seen_n = 1'b1;
          end
        end
      end

      default: state_n = SEQ_DEC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every register update from pre-edge values.
    if (rst) begin
      state     <= SEQ_DEC_IDLE;
      rate_q    <= PCDBitRate_106;
      last      <= PCDBitSequence_Y;
      bit_done  <= 1'b0;
      y_seen    <= 1'b0;
      pause_n_q <= 1'b1;
      seq       <= PCDBitSequence_Y;
      seq_valid <= 1'b0;
      idle      <= 1'b1;
    end else begin
      state     <= state_n;
      rate_q    <= rate_n;
      last      <= last_n;
      bit_done  <= bit_done_n;
      y_seen    <= y_seen_n;
      pause_n_q <= pause_n_synchronised;
      seq       <= seq_n;
      seq_valid <= seq_valid_n;
      idle      <= idle_n;
    end
  end

`ifdef SEQ_DECODE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
    end else if (seq_valid_n && (seq_n == PCDBitSequence_ERROR) && !(&err_count)) begin
      err_count <= err_count + 1'b1;
    end
  end
`endif

endmodule
